// File: rtl/cordic_microrot_iter_if.sv
// Handshake and data bundle between the initial +/-45 degree stage, the
// iterative micro-rotation engine and the quadrant-correction stage.
interface cordic_microrot_iter_if #(
  parameter int data_width   = 16,
  parameter int cordic_steps = 16
);
  logic                         enable;
  logic signed [data_width-1:0] x_vec_in;
  logic signed [data_width-1:0] y_vec_in;
  logic [cordic_steps-1:0]      micro_rotation_in;
  logic [1:0]                   quad_in;

  logic signed [data_width-1:0] x_vec_out;
  logic signed [data_width-1:0] y_vec_out;
  logic [cordic_steps-1:0]      micro_rotation_out;
  logic [1:0]                   quad_out;
  logic                         busy;
  logic                         done;

  modport master (
    output enable,
    output x_vec_in,
    output y_vec_in,
    output micro_rotation_in,
    output quad_in,
    input  x_vec_out,
    input  y_vec_out,
    input  micro_rotation_out,
    input  quad_out,
    input  busy,
    input  done
  );

  modport slave (
    input  enable,
    input  x_vec_in,
    input  y_vec_in,
    input  micro_rotation_in,
    input  quad_in,
    output x_vec_out,
    output y_vec_out,
    output micro_rotation_out,
    output quad_out,
    output busy,
    output done
  );
endinterface

// File: rtl/cordic_microrot_iter.sv
// Iterative CORDIC micro-rotation engine: one shift-add rotation per clock
// after the initial stage, driving y toward zero and recording directions.
//
// state    | meaning
// ---------+------------------------------------------------------------
// st_idle  | waiting for enable; output registers hold the last result
// st_iter  | performing micro-rotation number 'step' on each clock edge
module cordic_microrot_iter #(
  parameter int data_width   = 16,
  parameter int cordic_steps = 16
) (
  input logic                   clk,
  input logic                   nreset,
  cordic_microrot_iter_if.slave bus
);
  localparam int step_w = $clog2(cordic_steps);
  localparam logic [step_w-1:0] last_step = step_w'(cordic_steps - 1);

  localparam logic [0:0] st_idle = 1'b0;
  localparam logic [0:0] st_iter = 1'b1;

  logic [0:0]                   state;
  logic [step_w-1:0]            step;
  logic signed [data_width-1:0] x_wrk;
  logic signed [data_width-1:0] y_wrk;
  logic [cordic_steps-1:0]      rec_wrk;
  logic [1:0]                   quad_wrk;

  logic                         dir;
  logic signed [data_width-1:0] x_sh;
  logic signed [data_width-1:0] y_sh;
  logic signed [data_width-1:0] x_nxt;
  logic signed [data_width-1:0] y_nxt;
  logic [cordic_steps-1:0]      rec_nxt;

  logic signed [data_width-1:0] x_out_q;
  logic signed [data_width-1:0] y_out_q;
  logic [cordic_steps-1:0]      rec_out_q;
  logic [1:0]                   quad_out_q;
  logic                         busy_q;
  logic                         done_q;

  // y == 0 rotates clockwise, the same as any non-negative y
  always_comb begin
    dir  = ~y_wrk[data_width-1];
    x_sh = x_wrk >>> step;
    y_sh = y_wrk >>> step;
    if (dir) begin
      x_nxt = x_wrk + y_sh;
      y_nxt = y_wrk - x_sh;
    end else begin
      x_nxt = x_wrk - y_sh;
      y_nxt = y_wrk + x_sh;
    end
    rec_nxt       = rec_wrk;
    rec_nxt[step] = dir;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state      <= st_idle;
      step       <= '0;
      x_wrk      <= '0;
      y_wrk      <= '0;
      rec_wrk    <= '0;
      quad_wrk   <= '0;
      x_out_q    <= '0;
      y_out_q    <= '0;
      rec_out_q  <= '0;
      quad_out_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        st_idle: begin
          if (bus.enable) begin
            x_wrk    <= bus.x_vec_in;
            y_wrk    <= bus.y_vec_in;
            rec_wrk  <= bus.micro_rotation_in;
            quad_wrk <= bus.quad_in;
            step     <= step_w'(1);
            busy_q   <= 1'b1;
            state    <= st_iter;
          end
        end
        st_iter: begin
          x_wrk   <= x_nxt;
          y_wrk   <= y_nxt;
          rec_wrk <= rec_nxt;
          step    <= step + step_w'(1);
          // the last rotation goes straight to the outputs on the same edge
          if (step == last_step) begin
            x_out_q    <= x_nxt;
            y_out_q    <= y_nxt;
            rec_out_q  <= rec_nxt;
            quad_out_q <= quad_wrk;
            done_q     <= 1'b1;
            busy_q     <= 1'b0;
            state      <= st_idle;
          end
        end
        default: state <= st_idle;
      endcase
    end
  end

  assign bus.x_vec_out          = x_out_q;
  assign bus.y_vec_out          = y_out_q;
  assign bus.micro_rotation_out = rec_out_q;
  assign bus.quad_out           = quad_out_q;
  assign bus.busy               = busy_q;
  assign bus.done               = done_q;
endmodule

// File: tb/tb_cordic_microrot_iter.sv
// Self-checking bench for cordic_microrot_iter: scoreboard of golden results
// for the default configuration plus a directed 4-step instance.
module tb_cordic_microrot_iter;
  logic clk = 1'b0;
  logic nreset = 1'b0;

  always #5 clk = ~clk;

  cordic_microrot_iter_if #(.data_width(16), .cordic_steps(16)) bus ();
  cordic_microrot_iter_if #(.data_width(16), .cordic_steps(4))  bus4 ();

  cordic_microrot_iter #(.data_width(16), .cordic_steps(16)) dut (
    .clk(clk), .nreset(nreset), .bus(bus.slave));
  cordic_microrot_iter #(.data_width(16), .cordic_steps(4)) dut4 (
    .clk(clk), .nreset(nreset), .bus(bus4.slave));

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] rec;
    logic [1:0]  quad;
  } res_t;

  res_t sb[$];
  res_t held = '0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   cnt = 0;
  logic exp_busy = 1'b0;
  logic exp_done = 1'b0;
  int   n_done = 0;
  int   cyc = 0;
  int   last_done = -1;
  logic cont = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic res_t golden(input logic [15:0] xi, input logic [15:0] yi,
                                  input logic [15:0] ri, input logic [1:0] qi);
    logic signed [15:0] x, y, xn, yn;
    logic [15:0] r;
    res_t res;
    x = xi;
    y = yi;
    r = ri;
    for (int i = 1; i < 16; i++) begin
      if (y >= 0) begin
        xn = x + (y >>> i);
        yn = y - (x >>> i);
        r[i] = 1'b1;
      end else begin
        xn = x - (y >>> i);
        yn = y + (x >>> i);
        r[i] = 1'b0;
      end
      x = xn;
      y = yn;
    end
    res.x = x;
    res.y = y;
    res.rec = r;
    res.quad = qi;
    return res;
  endfunction

  // reference timing model: accepts, pushes the golden result, predicts busy/done
  always @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      cnt = 0;
      exp_busy = 1'b0;
      exp_done = 1'b0;
      sb.delete();
    end else begin
      exp_done = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          exp_done = 1'b1;
          exp_busy = 1'b0;
        end
      end else if (bus.enable) begin
        sb.push_back(golden(bus.x_vec_in, bus.y_vec_in, bus.micro_rotation_in, bus.quad_in));
        cnt = 15;
        exp_busy = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    cyc++;
    if (!nreset) held = '0;
    chk("done", bus.done, exp_done);
    chk("busy", bus.busy, exp_busy);
    if (bus.done) begin
      n_done++;
      chk("sb_has_entry", sb.size() != 0, 1);
      if (sb.size() != 0) held = sb.pop_front();
      if (cont && last_done >= 0) chk("done_period", cyc - last_done, 16);
      last_done = cyc;
    end
    chk("x_out", $unsigned(bus.x_vec_out), held.x);
    chk("y_out", $unsigned(bus.y_vec_out), held.y);
    chk("rec_out", bus.micro_rotation_out, held.rec);
    chk("quad_out", bus.quad_out, held.quad);
  end

  task automatic send(input logic [15:0] x, input logic [15:0] y,
                      input logic [15:0] rec, input logic [1:0] quad);
    @(posedge clk);
    #1;
    bus.x_vec_in = x;
    bus.y_vec_in = y;
    bus.micro_rotation_in = rec;
    bus.quad_in = quad;
    bus.enable = 1'b1;
    @(posedge clk);
    #1;
    bus.enable = 1'b0;
  endtask

  initial begin
    int nb, nd4, lat, d0;
    bus.enable = 1'b0;
    bus.x_vec_in = '0;
    bus.y_vec_in = '0;
    bus.micro_rotation_in = '0;
    bus.quad_in = '0;
    bus4.enable = 1'b0;
    bus4.x_vec_in = '0;
    bus4.y_vec_in = '0;
    bus4.micro_rotation_in = '0;
    bus4.quad_in = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_x", $unsigned(bus.x_vec_out), 0);
    chk("rst_rec", bus.micro_rotation_out, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst4_done", bus4.done, 0);
    nreset = 1'b1;

    // 4-step bit-exact run
    @(posedge clk);
    #1;
    bus4.x_vec_in = 16'sd1000;
    bus4.y_vec_in = 16'sd0;
    bus4.micro_rotation_in = 4'b0001;
    bus4.quad_in = 2'd2;
    bus4.enable = 1'b1;
    @(posedge clk);
    #1;
    bus4.enable = 1'b0;
    nb = 0;
    nd4 = 0;
    lat = -1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (bus4.busy) nb++;
      if (bus4.done) begin
        nd4++;
        lat = k - 1;
      end
    end
    chk("t4_latency", lat, 3);
    chk("t4_busy_cycles", nb, 3);
    chk("t4_done_count", nd4, 1);
    chk("t4_x", $unsigned(bus4.x_vec_out), 16'd1157);
    chk("t4_y", $unsigned(bus4.y_vec_out), 16'hFF92);
    chk("t4_rec", bus4.micro_rotation_out, 4'b0011);
    chk("t4_quad", bus4.quad_out, 2'd2);

    // enable held high with changing inputs
    @(posedge clk);
    #1;
    cont = 1'b1;
    d0 = n_done;
    for (int c = 0; c < 80; c++) begin
      bus.x_vec_in = 16'($urandom);
      bus.y_vec_in = 16'($urandom);
      bus.micro_rotation_in = 16'($urandom);
      bus.quad_in = 2'($urandom);
      bus.enable = 1'b1;
      @(posedge clk);
      #1;
    end
    bus.enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    cont = 1'b0;
    chk("cont_done_count", n_done - d0, 5);

    // second enable while busy is ignored
    d0 = n_done;
    send(16'sd2000, -16'sd700, 16'h0001, 2'd1);
    repeat (4) @(posedge clk);
    send(-16'sd500, 16'sd300, 16'h0001, 2'd0);
    repeat (25) @(posedge clk);
    #1;
    chk("busy_reject_dones", n_done - d0, 1);

    // reset during iteration 7
    d0 = n_done;
    send(16'sd12345, 16'sd4321, 16'h0001, 2'd3);
    repeat (6) @(posedge clk);
    #1;
    nreset = 1'b0;
    #1;
    chk("midrst_x", $unsigned(bus.x_vec_out), 0);
    chk("midrst_y", $unsigned(bus.y_vec_out), 0);
    chk("midrst_rec", bus.micro_rotation_out, 0);
    chk("midrst_quad", bus.quad_out, 0);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_done", bus.done, 0);
    repeat (2) @(posedge clk);
    #1;
    nreset = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("midrst_no_done", n_done - d0, 0);
    d0 = n_done;
    send(-16'sd3000, 16'sd9000, 16'h0001, 2'd2);
    repeat (18) @(posedge clk);
    #1;
    chk("post_rst_done", n_done - d0, 1);

    // sign and wrap boundaries
    send(16'sd32767, 16'sd32767, 16'h0001, 2'd0);
    repeat (18) @(posedge clk);
    send(16'h8000, 16'sd0, 16'h0001, 2'd1);
    repeat (18) @(posedge clk);
    send(16'sd0, 16'hFFFF, 16'h0000, 2'd2);
    repeat (18) @(posedge clk);
    send(16'sd1, 16'sd0, 16'h0001, 2'd3);
    repeat (18) @(posedge clk);

    // bit0 and quad pass through
    send(16'sd123, -16'sd456, 16'hFFFE, 2'd3);
    repeat (18) @(posedge clk);
    #1;
    chk("pass_bit0", bus.micro_rotation_out[0], 1'b0);
    chk("pass_quad", bus.quad_out, 2'd3);

    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/cordic_microrot_iter.md
Name: cordic_microrot_iter

Overview:
- Iterative CORDIC micro-rotation engine in the rotation path.
- Directly consumes the initial ±45° stage output: x/y vector, one-hot micro-rotation record, quadrant tag and done pulse.
- Performs the remaining cordic_steps-1 shift-add micro-rotations, one per clock, driving y toward zero and recording each direction bit.
- Presents the final vector, direction record and quadrant with a one-cycle done pulse to the quadrant-correction/angle stage.

Parameters:
- data_width, 16, signed width of x/y datapath.
- cordic_steps, 16, total micro-rotation count including the initial stage; must be >= 2. Step counter width is clog2(cordic_steps).

Ports:
- clk  input  1  clock
- nreset  input  1  asynchronous active-low reset
- enable  input  1  start strobe; connected to upstream done
- x_vec_in  input  data_width  signed x after initial stage
- y_vec_in  input  data_width  signed y after initial stage
- micro_rotation_in  input  cordic_steps  direction record; bit0 set by upstream
- quad_in  input  2  quadrant tag
- x_vec_out  output  data_width  signed final x
- y_vec_out  output  data_width  signed final y (residual)
- micro_rotation_out  output  cordic_steps  final direction record
- quad_out  output  2  quadrant tag passthrough
- busy  output  1  high while iterating
- done  output  1  one-cycle result-valid pulse

Behaviour:
- Reset: nreset is asynchronous and active-low; clock is clk. On reset, all outputs go to 0 (x/y/micro_rotation/quad outputs, busy, done), the internal working registers and step counter clear, and the FSM goes to IDLE.
- FSM has two states, IDLE and ITER, all registered.
- IDLE, enable=1:
  - Latch x_vec_in, y_vec_in, micro_rotation_in and quad_in into working registers.
  - Set step=1, busy<=1, go to ITER.
- IDLE, enable=0: hold. Output registers keep their last result.
- ITER, each clock, with i=step:
  - d = 1 if working y >= 0 (MSB=0), else 0; y==0 counts as d=1.
  - d=1: x' = x + (y>>>i), y' = y - (x>>>i).
  - d=0: x' = x - (y>>>i), y' = y + (x>>>i).
  - Both updates use pre-update x and y.
  - Write rec[i] <= d; step <= step+1.
- Final iteration (step == cordic_steps-1), on the same edge:
  - Load x', y', the updated record and the quad into the output registers.
  - done<=1, busy<=0, go to IDLE.
- done drops on the following edge. Outputs hold until the next completion.
- Arithmetic:
  - `>>>` is an arithmetic (sign-filling) shift.
  - Add/sub wraps modulo 2^data_width; no saturation, no growth bits.
  - A shift of i >= data_width yields 0 or -1.
- micro_rotation_in bit0 and quad_in pass through unchanged. Bits 1..cordic_steps-1 of the record are overwritten by the iterations.
- Latency: enable sampled at edge E gives done high after edge E+cordic_steps-1.
- Minimum start spacing is cordic_steps cycles. An enable on the done cycle is accepted.
- enable while busy (ITER) is ignored. No queueing, no effect on the run in progress.
- Reset mid-ITER aborts immediately. No done pulse; all outputs 0.
- Output registers change only on the final-iteration edge. Intermediate values never appear on the outputs.

Test Plan:
- Bit-exact iteration, cordic_steps=4, data_width=16: x=1000, y=0, rec=4'b0001, quad=2, one-cycle enable.
  - Required: done after 3 edges with x_vec_out=1157, y_vec_out=-110, micro_rotation_out=4'b0011, quad_out=2.
  - busy high for exactly 3 cycles.
- Default params, enable held high continuously with changing inputs: done pulses exactly every 16 cycles. Each result bit-exact against a golden model of the rules above, capturing the input present at each accepted edge.
- Busy rejection: second enable with x=-500, y=300 issued 5 cycles into a run. Required: a single done, with results of the first vector only, and busy never glitching.
- Reset mid-operation: assert nreset low at iteration 7.
  - Required: immediately all outputs 0 and no done pulse.
  - After release, a new vector completes normally with correct results.
- Sign/wrap boundaries, default params: vectors (32767,32767), (-32768,0), (0,-1) and (1,0). Required: outputs bit-exact to a golden model using wrap-around arithmetic and arithmetic shifts; y==0 takes d=1.
- Record passthrough: micro_rotation_in bit0=0 with upper bits all 1, quad_in=3. Required: micro_rotation_out bit0=0, upper bits equal the computed directions, quad_out=3.
